ifft16_tx: RTL and testbench

// - Iterative radix-2 DIT 16-point inverse FFT engine for the NB-IoT uplink transmit path.
// - Takes one 16-sample parallel frequency-domain vector from the subcarrier mapper, computes
//   x[n] = (1/16)*sum X[k]*W16^(-nk), and presents 16 parallel time samples to the CP inserter.
// - Inverse counterpart of the receive-side 16-point FFT datapath: conjugate twiddles, 1/2 per stage.

---
 rtl/ifft16_pkg.sv | 43 ++++
 rtl/ifft16_btrfly.sv | 56 +++++
 rtl/ifft16_tx.sv | 112 +++++++++++
 tb/tb_ifft16_tx.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifft16_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ifft16_pkg : shared types, Q4.12 constants and helpers for ifft16  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package ifft16_pkg;

    localparam int INT_WIDTH         = 4;
    localparam int FRAC_WIDTH        = 12;
    localparam int DATA_WIDTH        = INT_WIDTH + FRAC_WIDTH;
    localparam int DOUBLE_DATA_WIDTH = 2 * DATA_WIDTH;
    localparam int N_PTS             = 16;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] re;
        logic [DATA_WIDTH-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    // W16^-m = cos(2*pi*m/16) + j*sin(2*pi*m/16)
    localparam cplx_t TW16_INV [0:7] = '{
        '{re: 16'h1000, im: 16'h0000},
        '{re: 16'h0EC8, im: 16'h061F},
        '{re: 16'h0B50, im: 16'h0B50},
        '{re: 16'h061F, im: 16'h0EC8},
        '{re: 16'h0000, im: 16'h1000},
        '{re: 16'hF9E1, im: 16'h0EC8},
        '{re: 16'hF4B0, im: 16'h0B50},
        '{re: 16'hF138, im: 16'h061F}
    };

    function automatic logic [3:0] bitrev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifft16_btrfly.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ifft16_btrfly : radix-2 DIT butterfly, 1/2 scaling, saturation     |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ifft16_btrfly
    import ifft16_pkg::*;
(
    input  cplx_t top,
    input  cplx_t bot,
    input  cplx_t tw,
    output cplx_t top_new,
    output cplx_t bot_new
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int AW = PW + 1;
    localparam int SW = AW + 1;
    localparam logic signed [AW-1:0] RND   = AW'(2 ** (FRAC_WIDTH - 1));
    localparam logic signed [SW-1:0] MAX_V = SW'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [SW-1:0] MIN_V = SW'(-(2 ** (DATA_WIDTH - 1)));

    logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [AW-1:0] t_re, t_im;
    logic signed [SW-1:0] a_re, a_im, s_re, s_im, d_re, d_im;

    function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [SW-1:0] v);
        logic [DATA_WIDTH-1:0] r;
        r = v[DATA_WIDTH-1:0];
        if (v > MAX_V)
            r = MAX_V[DATA_WIDTH-1:0];
        else if (v < MIN_V)
            r = MIN_V[DATA_WIDTH-1:0];
        return r;
    endfunction

    always_comb begin
        p_rr = PW'($signed(bot.re)) * PW'($signed(tw.re));
        p_ii = PW'($signed(bot.im)) * PW'($signed(tw.im));
        p_ri = PW'($signed(bot.re)) * PW'($signed(tw.im));
        p_ir = PW'($signed(bot.im)) * PW'($signed(tw.re));
        // round half-up back to Q4.12 before the add/sub
        t_re = (AW'(p_rr) - AW'(p_ii) + RND) >>> FRAC_WIDTH;
        t_im = (AW'(p_ri) + AW'(p_ir) + RND) >>> FRAC_WIDTH;
        a_re = SW'($signed(top.re));
        a_im = SW'($signed(top.im));
        s_re = (a_re + SW'(t_re)) >>> 1;
        s_im = (a_im + SW'(t_im)) >>> 1;
        d_re = (a_re - SW'(t_re)) >>> 1;
        d_im = (a_im - SW'(t_im)) >>> 1;
        top_new = '{re: sat(s_re), im: sat(s_im)};
        bot_new = '{re: sat(d_re), im: sat(d_im)};
    end

endmodule
`default_nettype wire

// File: rtl/ifft16_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ifft16_tx : iterative in-place 16-point inverse FFT, 1 bfly/cycle  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ifft16_tx
    import ifft16_pkg::*;
(
    input  logic                                    i_clk_ifft16,
    input  logic                                    i_rst_n,
    input  logic                                    i_valid_ifft16,
    output logic                                    o_ready_ifft16,
    input  logic [N_PTS-1:0][DOUBLE_DATA_WIDTH-1:0] i_data_ifft16,
    output logic                                    o_valid_ifft16,
    input  logic                                    i_ready_ifft16,
    output logic [N_PTS-1:0][DOUBLE_DATA_WIDTH-1:0] o_data_ifft16,
    output logic                                    o_busy_ifft16
);

    state_t      state, state_nxt;
    logic [1:0]  stage;
    logic [2:0]  bfly;
    cplx_t       rf [N_PTS];

    logic [3:0]  half, top_idx, bot_idx;
    logic [2:0]  mask, j, g, tw_idx;
    cplx_t       bf_top, bf_bot;

    always_comb begin
        half    = 4'd1 << stage;
        mask    = 3'(half - 4'd1);
        j       = bfly & mask;
        g       = bfly >> stage;
        top_idx = ({1'b0, g} << (3'(stage) + 3'd1)) | {1'b0, j};
        bot_idx = top_idx | half;
        tw_idx  = j << (2'd3 - stage);
    end

    ifft16_btrfly u_btrfly (
        .top     (rf[top_idx]),
        .bot     (rf[bot_idx]),
        .tw      (TW16_INV[tw_idx]),
        .top_new (bf_top),
        .bot_new (bf_bot)
    );

    always_ff @(posedge i_clk_ifft16 or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        o_ready_ifft16 = 1'b0;
        o_busy_ifft16  = 1'b1;
        case (state)
            IDLE: begin
                o_ready_ifft16 = 1'b1;
                o_busy_ifft16  = 1'b0;
                if (i_valid_ifft16)
                    state_nxt = LOAD;
            end
            LOAD: state_nxt = CALC;
            CALC: if (stage == 2'd3 && bfly == 3'd7)
                      state_nxt = DONE;
            DONE: if (o_valid_ifft16 && i_ready_ifft16)
                      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk_ifft16 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stage          <= '0;
            bfly           <= '0;
            o_valid_ifft16 <= 1'b0;
            o_data_ifft16  <= '0;
            for (int r = 0; r < N_PTS; r++)
                rf[r] <= '0;
        end else begin
            case (state)
                IDLE: if (i_valid_ifft16 && o_ready_ifft16)
                          for (int r = 0; r < N_PTS; r++)
                              rf[r] <= i_data_ifft16[bitrev4(r[3:0])];
                LOAD: begin
                    stage <= '0;
                    bfly  <= '0;
                end
                CALC: begin
                    rf[top_idx]   <= bf_top;
                    rf[bot_idx]   <= bf_bot;
                    {stage, bfly} <= {stage, bfly} + 5'd1;
                end
                DONE: begin
                    // first DONE cycle registers the result; later cycles wait for the handshake
                    if (!o_valid_ifft16) begin
                        o_valid_ifft16 <= 1'b1;
                        for (int n = 0; n < N_PTS; n++)
                            o_data_ifft16[n] <= rf[n];
                    end else if (i_ready_ifft16) begin
                        o_valid_ifft16 <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifft16_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ifft16_tx : directed vectors, queue scoreboard + output monitor |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_ifft16_tx;
    import ifft16_pkg::*;

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b1;
    logic              i_valid = 1'b0;
    logic              i_ready = 1'b1;
    logic [15:0][31:0] din     = '0;
    logic              o_ready, o_valid, o_busy;
    logic [15:0][31:0] dout;

    typedef struct {
        logic [15:0][31:0] exp;
        logic [15:0]       chk;
        int                tol;
        int                acc;
        int                id;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   hs_cyc = -1;
    int   vec_id = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ifft16_tx dut (
        .i_clk_ifft16   (clk),
        .i_rst_n        (rst_n),
        .i_valid_ifft16 (i_valid),
        .o_ready_ifft16 (o_ready),
        .i_data_ifft16  (din),
        .o_valid_ifft16 (o_valid),
        .i_ready_ifft16 (i_ready),
        .o_data_ifft16  (dout),
        .o_busy_ifft16  (o_busy)
    );

    // per-component signed comparison within +-tol LSB
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req, input int tol);
        int dr, di;
        dr = int'($signed(act[31:16])) - int'($signed(req[31:16]));
        di = int'($signed(act[15:0]))  - int'($signed(req[15:0]));
        n_cmp++;
        if (dr > tol || dr < -tol || di > tol || di < -tol) begin
            n_fail++;
            $display("FAIL %s: got %08h, want %08h (+-%0d)", name, act, req, tol);
        end
    endtask

    task automatic send(input logic [15:0][31:0] vec, input logic [15:0][31:0] ex,
                        input logic [15:0] chk, input int tol, input bit keep,
                        output int acc);
        exp_t e;
        int   w;
        @(negedge clk);
        din     = vec;
        i_valid = 1'b1;
        w = 0;
        while (!o_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!o_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: got o_ready=0 after %0d cycles, want 1", w);
            acc = -1;
        end else begin
            acc   = cyc + 1;
            e.exp = ex;
            e.chk = chk;
            e.tol = tol;
            e.acc = acc;
            e.id  = vec_id;
            sb.push_back(e);
            @(negedge clk);
        end
        vec_id++;
        if (!keep)
            i_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() > 0 && w < 120) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (sb.size() > 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending, want 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    logic              prev_v  = 1'b0;
    logic              prev_hs = 1'b0;
    logic [15:0][31:0] prev_d  = '0;

    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            prev_v  = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (prev_v && !prev_hs) begin
                check("hold_valid", 32'(o_valid), 32'd1, 0);
                for (int n = 0; n < 16; n++)
                    check($sformatf("hold_x%0d", n), dout[n], prev_d[n], 0);
            end
            if (prev_hs) begin
                check("drop_valid", 32'(o_valid), 32'd0, 0);
                for (int n = 0; n < 16; n++)
                    check($sformatf("keep_x%0d", n), dout[n], prev_d[n], 0);
            end
            if (o_valid && !prev_v) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL spurious_valid: got o_valid=1, want no output");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check($sformatf("v%0d_latency", e.id), cyc - e.acc, 32'd34, 0);
                    for (int n = 0; n < 16; n++)
                        if (e.chk[n])
                            check($sformatf("v%0d_x%0d", e.id, n), dout[n], e.exp[n], e.tol);
                end
            end
            prev_hs = o_valid && i_ready;
            if (prev_hs)
                hs_cyc = cyc + 1;
            prev_v = o_valid;
            prev_d = dout;
        end
    end

    initial begin
        #200000;
        n_cmp++;
        n_fail++;
        $display("FAIL watchdog: got no completion, want finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        logic [15:0][31:0] v_imp, v_dc, v_tone, v_fs, ex_imp, ex_dc, ex_tone, ex_fs;
        int acc, acc2, w;

        v_imp = '0;  v_imp[0] = 32'h1000_0000;
        ex_imp = {16{32'h0100_0000}};
        v_dc = {16{32'h1000_0000}};
        ex_dc = '0;  ex_dc[0] = 32'h1000_0000;
        v_tone = '0; v_tone[1] = 32'h1000_0000;
        ex_tone = '0;
        ex_tone[0] = 32'h0100_0000; ex_tone[4]  = 32'h0000_0100;
        ex_tone[8] = 32'hFF00_0000; ex_tone[12] = 32'h0000_FF00;
        v_fs = {16{32'h7FFF_7FFF}};
        ex_fs = '0;  ex_fs[0] = 32'h7FFF_7FFF;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(o_ready), 32'd1, 0);
        check("rst_valid", 32'(o_valid), 32'd0, 0);
        check("rst_busy",  32'(o_busy),  32'd0, 0);
        check("rst_x0",    dout[0],      32'd0, 0);
        check("rst_x15",   dout[15],     32'd0, 0);
        rst_n = 1'b1;

        send(v_imp,  ex_imp,  16'hFFFF, 0, 1'b0, acc); drain();
        send(v_dc,   ex_dc,   16'hFFFF, 1, 1'b0, acc); drain();
        send(v_tone, ex_tone, 16'h1111, 1, 1'b0, acc); drain();
        send(v_fs,   ex_fs,   16'h0001, 2, 1'b0, acc); drain();

        // backpressure with the next vector already waiting on i_valid
        i_ready = 1'b0;
        send(v_dc, ex_dc, 16'hFFFF, 1, 1'b1, acc);
        din = v_tone;
        w = 0;
        while (!o_valid && w < 100) begin
            check("bp_ready_low", 32'(o_ready), 32'd0, 0);
            @(negedge clk);
            w++;
        end
        repeat (10) begin
            @(negedge clk);
            check("bp_ready_low", 32'(o_ready), 32'd0, 0);
            check("bp_busy",      32'(o_busy),  32'd1, 0);
        end
        i_ready = 1'b1;
        send(v_tone, ex_tone, 16'h1111, 1, 1'b0, acc2);
        check("accept_after_hs", acc2, hs_cyc + 1, 0);
        drain();

        // abort in the middle of CALC
        send(v_imp, ex_imp, 16'hFFFF, 0, 1'b0, acc);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(o_ready), 32'd1, 0);
        check("abort_valid", 32'(o_valid), 32'd0, 0);
        check("abort_busy",  32'(o_busy),  32'd0, 0);
        check("abort_x0",    dout[0],      32'd0, 0);
        if (sb.size() > 0)
            void'(sb.pop_back());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        send(v_imp, ex_imp, 16'hFFFF, 0, 1'b0, acc); drain();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
